uart_tx_mmio: RTL
=================

# uart_tx_mmio

Memory-mapped UART transmitter that sits downstream of the MIPS core's data port, next to the data memory. Stores to its data register push bytes into a small FIFO. A serialiser drains the FIFO onto `tx` as 8N1 frames. Loads from its status register let software poll for space, busy and overflow. The top level decodes nothing extra: this block decodes its own two-word window, and the data-memory path ignores addresses at or above `BASE_ADDR`.

## Interface
Parameters:
- `BASE_ADDR`, default 32'hFFFF_0000: word-aligned base of the register window.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit, minimum 2.
- `FIFO_DEPTH`, default 4: FIFO entries, power of two, minimum 2.

Ports:
- `clk`, input, 1: system clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `datawrite`, input, 1: store strobe from the core.
- `dataaddr`, input, 32: byte address from the core; bits [1:0] ignored.
- `writedata`, input, 32: store data; only bits [7:0] are used for the data register.
- `readdata`, output, 32: combinational load data for this window; 0 outside the window.
- `tx`, output, 1: serial line, idle high.

## Operation
Register map (word offsets from `BASE_ADDR`):
- +0x0 DATA, write-only. A store pushes `writedata[7:0]`. Reads return 0.
- +0x4 STATUS.
  - Read layout: bit0 full, bit1 empty, bit2 busy (serialiser not IDLE), bit3 overflow (sticky), bits[15:8] FIFO count, all other bits 0.
  - Any store to STATUS clears overflow.
- Addresses outside the window: writes ignored, `readdata` = 0.

Push rules:
- A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
- A rejected push drops the byte and sets overflow. FIFO contents are unchanged.

Serialiser FSM, states IDLE, START, DATA, STOP:
- IDLE: `tx` = 1. If the FIFO is non-empty, pop the head into the shift register, clear `baud_cnt`, go to START.
- START: `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with `bit_idx` = 0.
- DATA: `tx` = `shift[bit_idx]`, LSB first. Each bit lasts `CLKS_PER_BIT` cycles. After bit 7, go to STOP.
- STOP: `tx` = 1 for `CLKS_PER_BIT` cycles. On its last cycle:
  - if the FIFO is non-empty, pop and go to START, giving back-to-back frames with no idle gap;
  - otherwise go to IDLE.

Counter and pointer widths:
- `baud_cnt` is $clog2(`CLKS_PER_BIT`) bits and wraps at `CLKS_PER_BIT`-1.
- `bit_idx` is 3 bits.
- FIFO pointers are $clog2(`FIFO_DEPTH`) bits and wrap naturally.
- FIFO count is one bit wider than the pointers.

## Timing
Reset values: `tx` = 1, state IDLE, FIFO empty (count 0), overflow = 0, `baud_cnt` = 0, `bit_idx` = 0. `readdata` follows the reset state combinationally.

Latencies:
- A store at edge N makes the FIFO non-empty after N.
- IDLE pops at edge N+1, and `tx` falls after edge N+1.
- One frame lasts exactly 10×`CLKS_PER_BIT` cycles.

`readdata` has zero latency (combinational from `dataaddr` and current state), matching single-cycle data memory.

Simultaneous events:
- Push and pop in the same cycle with the FIFO full: push accepted, count unchanged, no overflow.
- Push and pop with the FIFO empty cannot occur, because a pop requires non-empty in the same cycle.
- A store to STATUS in the same cycle that an overflow occurs cannot happen; both are stores to different addresses.

Reset asserted mid-frame: `tx` returns to 1 immediately (asynchronously), the frame is abandoned and the FIFO is emptied.

## Structure
- Package `uart_pkg`:
  - register offsets `UART_DATA_OFS` = 0 and `UART_STAT_OFS` = 4;
  - status bit positions `ST_FULL`, `ST_EMPTY`, `ST_BUSY`, `ST_OVF`, `ST_CNT_LSB`;
  - FSM state enum `uart_state_t`.
- Sub-module `sync_fifo`:
  - parameters width 8 and `FIFO_DEPTH`;
  - ports `clk`, `reset`, push, pop, din, dout, full, empty, count;
  - dout shows the head combinationally.
- The top module holds address decode, the overflow flag and the serialiser FSM.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4 and `FIFO_DEPTH` = 4.
- Reset then read STATUS: `readdata` = 32'h0000_0002 and `tx` = 1.
- Store 8'h55 to DATA:
  - `tx` falls one cycle later;
  - `tx` then shows 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop), each held 4 cycles;
  - frame is 40 cycles, after which the state returns to IDLE and busy = 0.
- Store 8'hA1, 8'h02, 8'hFF in consecutive cycles:
  - three frames are emitted back to back;
  - the stop bit of each frame is followed directly by the next start bit;
  - total 120 cycles from the first falling edge.
- Six stores in consecutive cycles while idle:
  - the first byte is popped, the remaining five fill the FIFO to 4 and drop the last;
  - STATUS reads full = 1, overflow = 1, count = 4;
  - a store to STATUS then clears overflow only.
- With the FIFO full and a STOP→START pop pending, store in the pop cycle: push accepted, count stays 4, overflow stays 0.
- Assert `reset` during DATA bit 3:
  - `tx` goes to 1 without waiting for a clock;
  - after release STATUS = 32'h0000_0002 and no further frame is emitted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
package uart_pkg;

   // Register byte offsets from the window base
   localparam logic [31:0] UART_DATA_OFS = 32'h0000_0000;
   localparam logic [31:0] UART_STAT_OFS = 32'h0000_0004;

   // STATUS register bit positions
   localparam int unsigned ST_FULL    = 0;
   localparam int unsigned ST_EMPTY   = 1;
   localparam int unsigned ST_BUSY    = 2;
   localparam int unsigned ST_OVF     = 3;
   localparam int unsigned ST_CNT_LSB = 8;
   localparam int unsigned ST_CNT_W   = 8;

   // Serialiser states
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output and occupancy count.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_pop_c;
   logic             do_push_c;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it
   assign do_pop_c  = pop && !empty;
   assign do_push_c = push && (!full || do_pop_c);

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // Next pointer and occupancy values
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push_c) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push_c, do_pop_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push_c) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS window, byte FIFO and serialiser.
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        datawrite,
   input  logic [31:0] dataaddr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        tx
);

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [31:0]       DATA_ADDR = BASE_ADDR + UART_DATA_OFS;
   localparam logic [31:0]       STAT_ADDR = BASE_ADDR + UART_STAT_OFS;

   uart_state_t       state_q;
   logic [BAUD_W-1:0] baud_q;
   logic [2:0]        bit_idx_q;
   logic [7:0]        shift_q;
   logic              tx_q;
   logic              ovf_q, ovf_d;

   logic              sel_data_c;
   logic              sel_stat_c;
   logic              push_c;
   logic              stat_wr_c;
   logic              pop_c;
   logic              bit_last_c;
   logic [2:0]        next_idx_c;

   logic [7:0]        fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   logic              unused_bits_c;

   // Word-granular decode of the two-register window
   assign sel_data_c = (dataaddr[31:2] == DATA_ADDR[31:2]);
   assign sel_stat_c = (dataaddr[31:2] == STAT_ADDR[31:2]);
   assign push_c     = datawrite && sel_data_c;
   assign stat_wr_c  = datawrite && sel_stat_c;

   // Byte-lane and upper data bits play no part in this block
   assign unused_bits_c = ^{writedata[31:8], dataaddr[1:0]};

   // Pop from IDLE, or on the last STOP cycle for gap-free back-to-back frames
   assign bit_last_c = (baud_q == BAUD_LAST);
   assign pop_c      = !fifo_empty &&
                       ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_last_c));
   assign next_idx_c = bit_idx_q + 3'd1;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_c),
      .pop   (pop_c),
      .din   (writedata[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Sticky overflow: set by a dropped push, cleared by any STATUS store
   always_comb begin
      ovf_d = ovf_q;
      if (stat_wr_c) begin
         ovf_d = 1'b0;
      end else if (push_c && fifo_full && !pop_c) begin
         ovf_d = 1'b1;
      end
   end

   // Overflow flag register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   // Serialiser: line value is registered and changes on the same edge as the state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               tx_q <= 1'b1;
               if (pop_c) begin
                  shift_q <= fifo_dout;
                  baud_q  <= '0;
                  tx_q    <= 1'b0;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (bit_last_c) begin
                  baud_q    <= '0;
                  bit_idx_q <= '0;
                  tx_q      <= shift_q[0];
                  state_q   <= S_DATA;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            S_DATA: begin
               if (bit_last_c) begin
                  baud_q <= '0;
                  if (bit_idx_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     bit_idx_q <= next_idx_c;
                     tx_q      <= shift_q[next_idx_c];
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            S_STOP: begin
               if (bit_last_c) begin
                  baud_q <= '0;
                  if (pop_c) begin
                     shift_q <= fifo_dout;
                     tx_q    <= 1'b0;
                     state_q <= S_START;
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            default: begin
               tx_q    <= 1'b1;
               baud_q  <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign tx = tx_q;

   // Zero-latency load data; zero outside the window and for DATA
   always_comb begin
      readdata = '0;
      if (sel_stat_c) begin
         readdata[ST_FULL]                   = fifo_full;
         readdata[ST_EMPTY]                  = fifo_empty;
         readdata[ST_BUSY]                   = (state_q != S_IDLE);
         readdata[ST_OVF]                    = ovf_q;
         readdata[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(fifo_count);
      end
   end

endmodule
